// File: rtl/fp_div_pkg.sv
// Shared constants, FSM states and operand classification for the sequential FP divider.
package fp_div_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int ITERS   = MAN_W + 3;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} cls_t;

  // A zero exponent is treated as zero regardless of mantissa (subnormal flush).
  function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (e == '1) return (m == '0) ? INF : NAN;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, MSB first.
module fp_div_mant_core
  import fp_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [MAN_W:0]   ma,
  input  logic [MAN_W:0]   mb,
  output logic [ITERS-1:0] q,
  output logic             rem_nz
);

  logic [MAN_W+1:0] r_rem;
  logic [ITERS-1:0] r_q;
  logic             w_ge;
  logic [MAN_W+1:0] w_diff;

  assign w_ge   = (r_rem >= {1'b0, mb});
  assign w_diff = w_ge ? (r_rem - {1'b0, mb}) : r_rem;

  // The remainder stays below 2*mb, so 25 bits never overflow after the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_q   <= '0;
    end else if (load) begin
      r_rem <= {1'b0, ma};
      r_q   <= '0;
    end else if (step) begin
      r_rem <= w_diff << 1;
      r_q   <= {r_q[ITERS-2:0], w_ge};
    end
  end

  assign q      = r_q;
  assign rem_nz = (r_rem != '0);

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE 754 single-precision divider with start/done handshake.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_div_seq
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] n1,
  input  logic [31:0] n2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);

`ifdef FP_DIV_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'(EXP_MAX);
  localparam logic signed [EXP_W+1:0] ONE_S  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO_S = '0;

  state_t r_state, w_next;
  logic [31:0] r_n1, r_n2, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic signed [EXP_W+1:0] r_exp;
  logic r_dbz, r_inv;

  logic w_load, w_step, w_sign, w_special, w_specDbz, w_specInv;
  logic [31:0] w_specRes, w_packed;
  cls_t w_c1, w_c2;
  logic signed [EXP_W+1:0] w_e1, w_e2, w_eNorm, w_eFin;
  logic [ITERS-1:0] w_q;
  logic w_remNz, w_guard, w_sticky, w_inc;
  logic [MAN_W-1:0] w_mant, w_mantFin;
  logic [MAN_W:0] w_mantRnd;

  assign w_sign = r_n1[31] ^ r_n2[31];
  assign w_c1   = classify(r_n1[MAN_W +: EXP_W], r_n1[MAN_W-1:0]);
  assign w_c2   = classify(r_n2[MAN_W +: EXP_W], r_n2[MAN_W-1:0]);
  assign w_e1   = signed'({2'b00, r_n1[MAN_W +: EXP_W]});
  assign w_e2   = signed'({2'b00, r_n2[MAN_W +: EXP_W]});

  fp_div_mant_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .step   (w_step),
    .ma     ({1'b1, r_n1[MAN_W-1:0]}),
    .mb     ({1'b1, r_n2[MAN_W-1:0]}),
    .q      (w_q),
    .rem_nz (w_remNz)
  );

  // NaN outranks the invalid cases, which outrank the inf/zero shortcuts.
  always_comb begin
    w_special = 1'b1;
    w_specRes = '0;
    w_specDbz = 1'b0;
    w_specInv = 1'b0;
    if (w_c1 == NAN || w_c2 == NAN) begin
      w_specRes = QNAN;
    end else if ((w_c1 == ZERO && w_c2 == ZERO) || (w_c1 == INF && w_c2 == INF)) begin
      w_specRes = QNAN;
      w_specInv = 1'b1;
    end else if (w_c1 == INF) begin
      w_specRes = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_c2 == INF || w_c1 == ZERO) begin
      w_specRes = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_c2 == ZERO) begin
      w_specRes = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_specDbz = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      IDLE:    if (start) w_next = UNPACK;
      UNPACK: begin
        w_load = 1'b1;
        w_next = w_special ? DONE : DIVIDE;
      end
      DIVIDE: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) w_next = ROUND;
      end
      ROUND:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Normalise the 26-bit quotient, round, then range-check the exponent.
  always_comb begin
    w_eNorm  = r_exp;
    w_mant   = w_q[ITERS-2:2];
    w_guard  = w_q[1];
    w_sticky = w_q[0] | w_remNz;
    if (!w_q[ITERS-1]) begin
      w_eNorm  = r_exp - ONE_S;
      w_mant   = w_q[ITERS-3:1];
      w_guard  = w_q[0];
      w_sticky = w_remNz;
    end
    w_inc     = RNE_EN & w_guard & (w_sticky | w_mant[0]);
    w_mantRnd = {1'b0, w_mant} + (MAN_W+1)'(w_inc);
    w_eFin    = w_mantRnd[MAN_W] ? (w_eNorm + ONE_S) : w_eNorm;
    w_mantFin = w_mantRnd[MAN_W] ? '0 : w_mantRnd[MAN_W-1:0];
    if (w_eFin >= EMAX_S)
      w_packed = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_eFin <= ZERO_S)
      w_packed = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    else
      w_packed = {w_sign, w_eFin[EXP_W-1:0], w_mantFin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n1     <= '0;
      r_n2     <= '0;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_n1  <= n1;
        r_n2  <= n2;
        r_dbz <= 1'b0;
        r_inv <= 1'b0;
      end
      if (r_state == UNPACK) begin
        r_cnt <= '0;
        r_exp <= w_e1 - w_e2 + BIAS_S;
        if (w_special) begin
          r_result <= w_specRes;
          r_dbz    <= w_specDbz;
          r_inv    <= w_specInv;
        end
      end
      if (r_state == DIVIDE) r_cnt <= r_cnt + 1'b1;
      if (r_state == ROUND) r_result <= w_packed;
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign div_by_zero = r_dbz;
  assign invalid     = r_inv;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: arithmetic reference model plus directed vectors.
module tb_fp_div_seq;

`ifdef FP_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] n1 = '0, n2 = '0;
  logic        busy, done, div_by_zero, invalid;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .n1          (n1),
    .n2          (n2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .invalid     (invalid)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Reference division: exact integer quotient of the scaled mantissas, then IEEE rules.
  function automatic void modelDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic dbz,
                                   output logic inv, output int lat);
    int ea, eb, e, sh;
    logic s;
    bit za, zb, ia, ib, na, nb, g, st;
    longint unsigned ma, mb, num, q, r, m24, low;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    dbz = 1'b0;
    inv = 1'b0;
    lat = 2;
    res = '0;
    if (na || nb) res = 32'h7FC00000;
    else if ((za && zb) || (ia && ib)) begin
      res = 32'h7FC00000;
      inv = 1'b1;
    end else if (ia) res = {s, 8'hFF, 23'h0};
    else if (ib || za) res = {s, 31'h0};
    else if (zb) begin
      res = {s, 8'hFF, 23'h0};
      dbz = 1'b1;
    end else begin
      lat = 29;
      ma  = 64'h800000 | 64'(a[22:0]);
      mb  = 64'h800000 | 64'(b[22:0]);
      num = ma << 25;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb + 127;
      if (q >= (64'd1 << 25)) sh = 2;
      else begin
        sh = 1;
        e  = e - 1;
      end
      m24 = q >> sh;
      g   = ((q >> (sh - 1)) & 64'd1) != 0;
      low = q & ((64'd1 << (sh - 1)) - 64'd1);
      st  = (low != 0) || (r != 0);
      if (RNE && g && (st || m24[0])) m24 = m24 + 1;
      if (m24 == (64'd1 << 24)) begin
        m24 = 64'd1 << 23;
        e   = e + 1;
      end
      if (e >= 255) res = {s, 8'hFF, 23'h0};
      else if (e <= 0) res = {s, 31'h0};
      else res = {s, 8'(e), m24[22:0]};
    end
  endfunction

  typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     mPhase = M_IDLE;
  int          mLeft = 0;
  logic [31:0] mRes = '0, mPendRes = '0, tRes;
  logic        mDbz = 1'b0, mInv = 1'b0, mPendDbz = 1'b0, mPendInv = 1'b0, tDbz, tInv;
  int          tLat;

  // Handshake model: accept only when idle, publish the result after the modelled latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase <= M_IDLE;
      mLeft  <= 0;
      mRes   <= '0;
      mDbz   <= 1'b0;
      mInv   <= 1'b0;
    end else begin
      case (mPhase)
        M_IDLE: if (start) begin
          modelDiv(n1, n2, tRes, tDbz, tInv, tLat);
          mPendRes <= tRes;
          mPendDbz <= tDbz;
          mPendInv <= tInv;
          mLeft    <= tLat - 1;
          mDbz     <= 1'b0;
          mInv     <= 1'b0;
          mPhase   <= M_BUSY;
        end
        M_BUSY: if (mLeft == 1) begin
          mPhase <= M_DONE;
          mRes   <= mPendRes;
          mDbz   <= mPendDbz;
          mInv   <= mPendInv;
        end else begin
          mLeft <= mLeft - 1;
        end
        default: mPhase <= M_IDLE;
      endcase
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkVal("cycle busy", {31'd0, busy}, {31'd0, mPhase != M_IDLE});
    checkVal("cycle done", {31'd0, done}, {31'd0, mPhase == M_DONE});
    checkVal("cycle result", result, mRes);
    checkVal("cycle div_by_zero", {31'd0, div_by_zero}, {31'd0, mDbz});
    checkVal("cycle invalid", {31'd0, invalid}, {31'd0, mInv});
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    n1    = a;
    n2    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL done timeout: got no done within %0d edges, expected done", lat);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v, input int lat);
    checkVal($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
    checkVal($sformatf("vec%0d result", idx), result, v.res);
    checkVal($sformatf("vec%0d div_by_zero", idx), {31'd0, div_by_zero}, {31'd0, v.dbz});
    checkVal($sformatf("vec%0d invalid", idx), {31'd0, invalid}, {31'd0, v.inv});
    checkVal($sformatf("vec%0d busy", idx), {31'd0, busy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int doneCount;
    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 29});
    vecs.push_back('{32'h3F800000, 32'h40400000, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, 1'b0, 1'b0, 29});
    vecs.push_back('{32'hC0800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 2});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 2});
    vecs.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 29});
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 29});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 2});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h40400000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h80000001, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 1'b0, 29});
    vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, RNE ? 32'h3F800001 : 32'h3F800000, 1'b0, 1'b0, 29});
    vecs.push_back('{32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, 1'b0, 29});

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("reset busy", {31'd0, busy}, 32'd0);
    checkVal("reset done", {31'd0, done}, 32'd0);
    checkVal("reset result", result, 32'd0);
    checkVal("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    checkVal("reset invalid", {31'd0, invalid}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput(i, vecs[i], lat);
    end

    // A start during the DONE cycle must be dropped.
    @(negedge clk);
    n1    = 32'h40C00000;
    n2    = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkVal("done-cycle latency", 32'(lat), 32'd29);
    n1    = 32'h41200000;
    n2    = 32'h40A00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("done-cycle start ignored busy", {31'd0, busy}, 32'd0);
    checkVal("done-cycle start ignored result", result, 32'h40400000);

    // Starts while busy are neither accepted nor queued.
    @(negedge clk);
    n1    = 32'h40C00000;
    n2    = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5 || c == 15) begin
        n1    = 32'h41200000;
        n2    = 32'h40A00000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) doneCount++;
    end
    start = 1'b0;
    checkVal("busy-start done count", 32'(doneCount), 32'd1);
    checkVal("busy-start result", result, 32'h40400000);
    repeat (5) @(negedge clk);
    checkVal("held result", result, 32'h40400000);
    checkVal("held div_by_zero", {31'd0, div_by_zero}, 32'd0);
    checkVal("held invalid", {31'd0, invalid}, 32'd0);

    // Reset in the middle of the divide loop aborts the operation.
    @(negedge clk);
    n1    = 32'h40C00000;
    n2    = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkVal("abort busy", {31'd0, busy}, 32'd0);
    checkVal("abort done", {31'd0, done}, 32'd0);
    checkVal("abort result", result, 32'd0);
    checkVal("abort div_by_zero", {31'd0, div_by_zero}, 32'd0);
    checkVal("abort invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkVal("abort no done", 32'(doneCount), 32'd0);
    applyStimulus(32'h41200000, 32'h40A00000, lat);
    checkOutput(99, '{32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, 1'b0, 29}, lat);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Multi-cycle IEEE 754 single-precision divider (n1 / n2). It is the inverse operation of the combinational add/sub/mul ALU's multiplier.
- Same operand and result naming as the ALU (n1, n2, result), so the two can share a bench and a result mux.
- Uses radix-2 restoring mantissa division with a start/done handshake.
- Subnormals are flushed to zero on input and output.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width. Iteration count is MAN_W+3.
- QNAN, 32'h7FC00000, canonical NaN returned for invalid operations.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- n1  input  32  dividend, captured on the accepting edge
- n2  input  32  divisor, captured on the accepting edge
- busy  output  1  high from the accept edge until done deasserts
- done  output  1  one-cycle pulse; result is valid while it is high and held afterwards
- result  output  32  quotient, stable until the next accepted start
- div_by_zero  output  1  finite nonzero / zero occurred; held with result
- invalid  output  1  0/0 or inf/inf occurred; held with result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, result, div_by_zero, invalid all 0; iteration counter 0. Reset mid-operation aborts the operation; no done is produced.
- FSM states and transitions:
  - IDLE -> UNPACK when start=1; operands are latched on that edge.
  - UNPACK -> DONE for special cases; otherwise -> DIVIDE.
  - DIVIDE runs MAN_W+3 iterations (26), then -> ROUND.
  - ROUND -> DONE.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- start while busy is ignored and not queued. A start in the DONE cycle is ignored; start is accepted in the cycle after.
- Latency, counted as edges after the accept edge until done is high:
  - normal path: MAN_W+6 = 29
  - special path: 2
- Unpack:
  - sign = s1 ^ s2.
  - A field with exponent 0 is treated as zero, whatever its mantissa.
  - Exponent all-ones with mantissa 0 is inf; with nonzero mantissa it is NaN.
- Special cases (result, flags):
  - either operand NaN -> QNAN, invalid=0
  - 0/0 or inf/inf -> QNAN, invalid=1
  - inf/x -> signed inf
  - x/inf -> signed zero
  - 0/x -> signed zero
  - x/0 (x finite, nonzero) -> signed inf, div_by_zero=1
- Divide:
  - Mantissas: ma={1,M1}, mb={1,M2}, 24 bits each. rem starts at ma, 25 bits.
  - Each iteration: if rem>=mb then q bit=1 and rem-=mb, else q bit=0; then rem<<=1.
  - The 26 quotient bits go MSB first into q[25:0].
- Exponent: e = E1 - E2 + 127, computed in a 10-bit signed intermediate.
- Normalise in ROUND:
  - q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0] | (rem!=0).
  - q[25]=0: e=e-1, mant=q[23:1], guard=q[0], sticky=(rem!=0).
- Rounding follows the optional feature below. A mantissa carry-out sets mant=0 and increments e.
- Range:
  - e>=255 -> signed inf, no flag.
  - e<=0 -> signed zero (flush).
- Flags are cleared on each accept and updated with result.

Optional Feature:
- FP_DIV_RNE_EN defined: round-to-nearest-even. Increment mant when guard & (sticky | mant[0]).
- Undefined: truncation. guard and sticky are discarded; rounding carry-out is impossible.
- Latency is identical in both builds.

Decomposition:
- fp_div_pkg holds:
  - field-width constants EXP_W, MAN_W, BIAS=127
  - EXP_MAX=255 and QNAN
  - the state enum {IDLE, UNPACK, DIVIDE, ROUND, DONE}
  - a classify typedef {ZERO, NORMAL, INF, NAN}
- One sub-module, fp_div_mant_core: the restoring iterator.
  - Inputs: load, ma, mb, step.
  - Outputs: q, rem_nz.
  - Top-level fp_div_seq owns the FSM, unpack, special cases and round/pack.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, done exactly 29 cycles after accept, flags 0, busy high throughout.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FP_DIV_RNE_EN, 0x3EAAAAAA without.
- 0xC0800000 / 0x00000000 (-4/0) -> 0xFF800000, div_by_zero=1, done 2 cycles after accept. Then 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1, div_by_zero=0.
- 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow). 0x00800000 / 0x7F000000 -> 0x00000000 (underflow flush).
- start pulsed at cycles 5 and 15 during one operation -> exactly one done. result and flags are unchanged between done and the next accept.
- rst_n dropped at iteration 10 of a 6.0/2.0 divide -> all outputs 0 immediately, no done. A new 0x41200000 / 0x40A00000 (10/5) -> 0x40000000.
